// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the unified memory port.
// Contents: default address/data widths, rw encoding, grant encoding.
`timescale 1ns/1ps
package mem_pkg;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_DEPTH_LOG2 = 8;
  localparam int unsigned DEF_STARVE_MAX = 3;

  // rw encoding seen on the data request port
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Which requester owns the RAM this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

endpackage

// File: rtl/mem_sp_ram.sv
// mem_sp_ram: single-port synchronous RAM, 1-cycle read latency.
// Ports: clk; en (access enable); we (write when en); addr; wdata;
//        rdata (word read at the last enabled edge, held otherwise).
// Contents are not cleared by any reset.
`timescale 1ns/1ps
module mem_sp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Read-first array access; rdata only moves on enabled cycles
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/unified_mem_port.sv
// unified_mem_port: single-port memory responder shared by instruction
// fetch and data load/store, with data priority and a fetch starvation guard.
// Ports: clk, reset (sync, active-high);
//        fetch:  i_req, i_addr -> ir, i_valid;
//        data:   d_req, d_addr, rw, dw_data -> dr, d_valid;
//        stall (combinational), addr_err (pulses with the matching valid).
`timescale 1ns/1ps
module unified_mem_port
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] ir,
  output logic              i_valid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] dw_data,
  output logic [DATA_W-1:0] dr,
  output logic              d_valid,
  output logic              stall,
  output logic              addr_err
);

  localparam int unsigned CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  gnt_e                  gnt_c;
  logic                  grant_i;
  logic                  grant_d;
  logic                  starved;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  g_i_q,   g_i_d;
  logic                  g_d_q,   g_d_d;
  logic                  g_rw_q,  g_rw_d;
  logic                  g_err_q, g_err_d;
  logic [DATA_W-1:0]     ir_hold_q, ir_hold_d;
  logic [DATA_W-1:0]     dr_hold_q, dr_hold_d;
  logic [ADDR_W-1:0]     acc_addr;
  logic                  acc_in_range;
  logic                  ram_en;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DATA_W-1:0]     rd_val;

  assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Arbiter: data first unless fetch has lost STARVE_MAX times in a row
  always_comb begin
    gnt_c = GNT_NONE;
    if (d_req && !(i_req && starved)) begin
      gnt_c = GNT_D;
    end else if (i_req) begin
      gnt_c = GNT_I;
    end
  end

  assign grant_i = (gnt_c == GNT_I);
  assign grant_d = (gnt_c == GNT_D);
  assign stall   = (i_req & ~grant_i) | (d_req & ~grant_d);

  // Starvation counter: counts data wins over a waiting fetch, saturating
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || grant_i) begin
      starve_cnt_d = '0;
    end else if (grant_d && !starved) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Granted address and range check; high bits must be zero, no wrap
  always_comb begin
    acc_addr     = grant_i ? i_addr : d_addr;
    acc_in_range = (acc_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    ram_addr     = acc_addr[DEPTH_LOG2-1:0];
    ram_en       = (grant_i | grant_d) & acc_in_range & ~reset;
    ram_we       = grant_d & (rw == RW_WRITE) & acc_in_range & ~reset;
  end

  mem_sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (dw_data),
    .rdata (ram_rdata)
  );

  // Response-cycle bookkeeping and held read data
  always_comb begin
    g_i_d     = grant_i;
    g_d_d     = grant_d;
    g_rw_d    = grant_d ? rw : RW_READ;
    g_err_d   = (grant_i | grant_d) & ~acc_in_range;
    rd_val    = g_err_q ? '0 : ram_rdata;
    ir_hold_d = g_i_q ? rd_val : ir_hold_q;
    dr_hold_d = (g_d_q && (g_rw_q == RW_READ)) ? rd_val : dr_hold_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      g_i_q        <= 1'b0;
      g_d_q        <= 1'b0;
      g_rw_q       <= RW_READ;
      g_err_q      <= 1'b0;
      ir_hold_q    <= '0;
      dr_hold_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      g_i_q        <= g_i_d;
      g_d_q        <= g_d_d;
      g_rw_q       <= g_rw_d;
      g_err_q      <= g_err_d;
      ir_hold_q    <= ir_hold_d;
      dr_hold_q    <= dr_hold_d;
    end
  end

  // Read data appears in the response cycle straight from the RAM register
  assign ir       = ir_hold_d;
  assign dr       = dr_hold_d;
  assign i_valid  = g_i_q;
  assign d_valid  = g_d_q;
  assign addr_err = g_err_q;

endmodule

// File: tb/tb_unified_mem_port.sv
// tb_unified_mem_port: scoreboard bench for unified_mem_port.
// Stimulus pushes hand-computed responses (data, err, response cycle) into
// per-port queues; a negedge monitor pops and compares on every valid.
`timescale 1ns/1ps
module tb_unified_mem_port;
  import mem_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] ir;
  logic          i_valid;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          rw = 1'b1;
  logic [DW-1:0] dw_data = '0;
  logic [DW-1:0] dr;
  logic          d_valid;
  logic          stall;
  logic          addr_err;

  always #5 clk = ~clk;

  unified_mem_port dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .ir       (ir),
    .i_valid  (i_valid),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .rw       (rw),
    .dw_data  (dw_data),
    .dr       (dr),
    .d_valid  (d_valid),
    .stall    (stall),
    .addr_err (addr_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t exp_i[$];
  exp_t exp_d[$];
  exp_t ei, ed;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Drive one cycle of requests just after the rising edge
  task automatic step(input logic iq, input logic [AW-1:0] ia,
                      input logic dq, input logic [AW-1:0] da,
                      input logic r, input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    i_req = iq; i_addr = ia; d_req = dq; d_addr = da; rw = r; dw_data = wd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, RW_READ, '0);
  endtask

  // Expected responses arrive one cycle after the grant cycle
  task automatic push_i(input logic [DW-1:0] data, input logic err);
    exp_t e;
    e.data = data; e.err = err; e.cyc = cyc_cnt + 1;
    exp_i.push_back(e);
  endtask

  task automatic push_d(input logic [DW-1:0] data, input logic err);
    exp_t e;
    e.data = data; e.err = err; e.cyc = cyc_cnt + 1;
    exp_d.push_back(e);
  endtask

  task automatic chk_stall(input logic exp);
    #1;
    chk("stall", stall, exp);
  endtask

  // Monitor: compare every presented response against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (i_valid) begin
        if (exp_i.size() == 0) begin
          chk("i_valid_unexpected", i_valid, 1'b0);
        end else begin
          ei = exp_i.pop_front();
          chk("ir", ir, ei.data);
          chk("i_addr_err", addr_err, ei.err);
          chk("i_valid_cycle", cyc_cnt, ei.cyc);
        end
      end
      if (d_valid) begin
        if (exp_d.size() == 0) begin
          chk("d_valid_unexpected", d_valid, 1'b0);
        end else begin
          ed = exp_d.pop_front();
          chk("dr", dr, ed.data);
          chk("d_addr_err", addr_err, ed.err);
          chk("d_valid_cycle", cyc_cnt, ed.cyc);
        end
      end
      if (!i_valid && !d_valid) chk("addr_err_idle", addr_err, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc_cnt);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_ir", ir, 16'h0000);
    chk("reset_dr", dr, 16'h0000);
    chk("reset_i_valid", i_valid, 1'b0);
    chk("reset_d_valid", d_valid, 1'b0);
    chk("reset_addr_err", addr_err, 1'b0);
    chk("reset_stall", stall, 1'b0);

    // Preload mem[5] and mem[0], then fetch mem[5]
    step(1'b0, '0, 1'b1, 16'h0005, RW_WRITE, 16'h1234); push_d(16'h0000, 1'b0);
    step(1'b0, '0, 1'b1, 16'h0000, RW_WRITE, 16'h0A0A); push_d(16'h0000, 1'b0);
    step(1'b1, 16'h0005, 1'b0, '0, RW_READ, '0);        push_i(16'h1234, 1'b0);
    chk_stall(1'b0);
    idle(2);

    // Store then load of the same address on consecutive grants
    step(1'b0, '0, 1'b1, 16'h0007, RW_WRITE, 16'hBEEF); push_d(16'h0000, 1'b0);
    step(1'b0, '0, 1'b1, 16'h0007, RW_READ, '0);        push_d(16'hBEEF, 1'b0);
    idle(2);

    // Contention: data first, fetch next cycle
    step(1'b0, '0, 1'b1, 16'h0003, RW_WRITE, 16'h0033); push_d(16'hBEEF, 1'b0);
    step(1'b1, 16'h0005, 1'b1, 16'h0003, RW_READ, '0);  push_d(16'h0033, 1'b0);
    chk_stall(1'b1);
    step(1'b1, 16'h0005, 1'b0, '0, RW_READ, '0);        push_i(16'h1234, 1'b0);
    chk_stall(1'b0);
    idle(2);

    // Starvation: both held high; 3 data wins then 1 fetch, repeating
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 16'h0005, 1'b1, 16'h0007, RW_READ, '0);
      if ((k % 4) == 3) push_i(16'h1234, 1'b0);
      else              push_d(16'hBEEF, 1'b0);
      chk_stall(1'b1);
    end
    idle(2);

    // Out of range accesses: no write, zero read data, error pulse
    step(1'b0, '0, 1'b1, 16'h0100, RW_WRITE, 16'hDEAD); push_d(16'hBEEF, 1'b1);
    step(1'b0, '0, 1'b1, 16'h0100, RW_READ, '0);        push_d(16'h0000, 1'b1);
    step(1'b0, '0, 1'b1, 16'h8005, RW_WRITE, 16'h5A5A); push_d(16'h0000, 1'b1);
    step(1'b1, 16'h0000, 1'b0, '0, RW_READ, '0);        push_i(16'h0A0A, 1'b0);
    step(1'b1, 16'h0005, 1'b0, '0, RW_READ, '0);        push_i(16'h1234, 1'b0);
    step(1'b1, 16'h0200, 1'b0, '0, RW_READ, '0);        push_i(16'h0000, 1'b1);
    step(1'b1, 16'h0000, 1'b0, '0, RW_READ, '0);        push_i(16'h0A0A, 1'b0);

    // Reset in the grant cycle: responses dropped, store suppressed
    @(posedge clk);
    #1;
    reset = 1'b1;
    i_req = 1'b1; i_addr = 16'h0005;
    d_req = 1'b1; d_addr = 16'h0007; rw = RW_WRITE; dw_data = 16'h5555;
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; rw = RW_READ;
    @(negedge clk);
    chk("post_reset_i_valid", i_valid, 1'b0);
    chk("post_reset_d_valid", d_valid, 1'b0);
    chk("post_reset_ir", ir, 16'h0000);
    chk("post_reset_dr", dr, 16'h0000);
    idle(1);
    step(1'b0, '0, 1'b1, 16'h0007, RW_READ, '0);        push_d(16'hBEEF, 1'b0);
    idle(3);

    chk("exp_i_left", exp_i.size(), 0);
    chk("exp_d_left", exp_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
